// File: rtl/encoder_4x2_pkg.sv
// Shared widths, reset constant and helper for the 4-to-2 priority encoder.
package encoder_pkg;

    localparam int ENC_IN_W  = 4;
    localparam int ENC_OUT_W = 2;

    // B reads 00 both out of reset and for an all-zero request; consumers qualify with valid.
    localparam logic [ENC_OUT_W-1:0] ENC_B_RST = 2'b00;

    // Number of set bits in a request vector (0..4 fits in 3 bits).
    function automatic logic [2:0] enc_popcount(input logic [ENC_IN_W-1:0] vec);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            cnt = cnt + 3'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_4x2_if.sv
// Request vector in, registered index/flags out.
interface encoder_4x2_if;
    import encoder_pkg::*;

    logic [ENC_IN_W-1:0]  D;
    logic [ENC_OUT_W-1:0] B;
    logic                 valid;
    logic                 multi;

    // Producer side: drives requests, observes the encoded result.
    modport master (
        output D,
        input  B,
        input  valid,
        input  multi
    );

    // Encoder side.
    modport slave (
        input  D,
        output B,
        output valid,
        output multi
    );

endinterface

// File: rtl/encoder_4x2_core.sv
// Unregistered 4-to-2 priority encoder; D[3] has the highest priority.
// Usable on its own wherever a combinational encoder is wanted.
module encoder_4x2_core
    import encoder_pkg::*;
(
    input  logic [ENC_IN_W-1:0]  D,
    output logic [ENC_OUT_W-1:0] b_next,
    output logic                 valid_next,
    output logic                 multi_next
);

    // Highest set bit wins; all-zero falls back to the reset index with valid low.
    always_comb begin
        b_next     = ENC_B_RST;
        valid_next = 1'b0;
        multi_next = 1'b0;
        casez (D)
            4'b1???: b_next = 2'b11;
            4'b01??: b_next = 2'b10;
            4'b001?: b_next = 2'b01;
            4'b0001: b_next = 2'b00;
            default: b_next = ENC_B_RST;
        endcase
        valid_next = |D;
        multi_next = (enc_popcount(D) >= 3'd2);
    end

endmodule

// File: rtl/encoder_4x2.sv
// Registered 4-to-2 priority encoder: one-cycle latency, loads every cycle,
// synchronous active-high reset. No combinational path from D to outputs.
module encoder_4x2
    import encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    encoder_4x2_if.slave bus
);

    logic [ENC_OUT_W-1:0] b_next;
    logic                 valid_next;
    logic                 multi_next;

    logic [ENC_OUT_W-1:0] b_d;
    logic                 valid_d;
    logic                 multi_d;

    logic [ENC_OUT_W-1:0] b_q;
    logic                 valid_q;
    logic                 multi_q;

    encoder_4x2_core u_core (
        .D          (bus.D),
        .b_next     (b_next),
        .valid_next (valid_next),
        .multi_next (multi_next)
    );

    // Next register values: reset constants win over the encoded request.
    always_comb begin
        b_d     = b_next;
        valid_d = valid_next;
        multi_d = multi_next;
        if (rst) begin
            b_d     = ENC_B_RST;
            valid_d = 1'b0;
            multi_d = 1'b0;
        end
    end

    // Output register stage, updated every rising edge.
    always_ff @(posedge clk) begin
        b_q     <= b_d;
        valid_q <= valid_d;
        multi_q <= multi_d;
    end

    assign bus.B     = b_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder_4x2.sv
// Scoreboard bench for encoder_4x2: the driver pushes the expected result of
// each cycle's input, the monitor pops and compares one cycle later.
module tb_encoder_4x2;

    typedef struct {
        logic [1:0] b;
        logic       valid;
        logic       multi;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    encoder_4x2_if bus_if ();

    encoder_4x2 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference priority rule: scan from the top bit down, count set bits.
    function automatic exp_t model(input logic [3:0] d, input logic r, input string tag);
        exp_t e;
        int   ones;
        e.b     = 2'b00;
        e.valid = 1'b0;
        e.multi = 1'b0;
        e.tag   = tag;
        ones    = 0;
        if (!r) begin
            for (int i = 0; i < 4; i++) ones += int'(d[i]);
            for (int i = 3; i >= 0; i--) begin
                if (d[i] && !e.valid) begin
                    e.b     = 2'(i);
                    e.valid = 1'b1;
                end
            end
            e.multi = (ones >= 2);
        end
        return e;
    endfunction

    // Drive one cycle of stimulus on the falling edge and record its expected result.
    task automatic drive(input logic [3:0] d, input logic r, input logic [1:0] b_exp,
                         input logic v_exp, input logic m_exp, input string tag);
        exp_t e;
        @(negedge clk);
        bus_if.D = d;
        rst      = r;
        e.b      = b_exp;
        e.valid  = v_exp;
        e.multi  = m_exp;
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive_model(input logic [3:0] d, input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        bus_if.D = d;
        rst      = r;
        e        = model(d, r, tag);
        exp_q.push_back(e);
    endtask

    // Monitor: every edge presents a new output; compare it against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus_if.B !== e.b) begin
                    n_errors++;
                    $display("FAIL %s B: got %b want %b", e.tag, bus_if.B, e.b);
                end
                n_checks++;
                if (bus_if.valid !== e.valid) begin
                    n_errors++;
                    $display("FAIL %s valid: got %b want %b", e.tag, bus_if.valid, e.valid);
                end
                n_checks++;
                if (bus_if.multi !== e.multi) begin
                    n_errors++;
                    $display("FAIL %s multi: got %b want %b", e.tag, bus_if.multi, e.multi);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        bus_if.D = 4'b1111;

        // Reset held with all requests set.
        drive(4'b1111, 1'b1, 2'b00, 1'b0, 1'b0, "reset0");
        drive(4'b1111, 1'b1, 2'b00, 1'b0, 1'b0, "reset1");

        // One-hot sweep including the empty vector.
        drive(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, "zero");
        drive(4'b0010, 1'b0, 2'b01, 1'b1, 1'b0, "oh1");
        drive(4'b0100, 1'b0, 2'b10, 1'b1, 1'b0, "oh2");
        drive(4'b1000, 1'b0, 2'b11, 1'b1, 1'b0, "oh3");
        drive(4'b0001, 1'b0, 2'b00, 1'b1, 1'b0, "oh0");

        // Priority with several bits set.
        drive(4'b0110, 1'b0, 2'b10, 1'b1, 1'b1, "pri0110");
        drive(4'b1111, 1'b0, 2'b11, 1'b1, 1'b1, "pri1111");
        drive(4'b1010, 1'b0, 2'b11, 1'b1, 1'b1, "pri1010");
        drive(4'b0011, 1'b0, 2'b01, 1'b1, 1'b1, "pri0011");

        // Mid-stream single-cycle reset pulse.
        drive(4'b1000, 1'b0, 2'b11, 1'b1, 1'b0, "strm_a");
        drive(4'b1000, 1'b0, 2'b11, 1'b1, 1'b0, "strm_b");
        drive(4'b1000, 1'b1, 2'b00, 1'b0, 1'b0, "strm_rst");
        drive(4'b1000, 1'b0, 2'b11, 1'b1, 1'b0, "strm_post0");
        drive(4'b1000, 1'b0, 2'b11, 1'b1, 1'b0, "strm_post1");

        // Exhaustive back-to-back sweep.
        for (int v = 0; v < 16; v++) begin
            drive_model(4'(v), 1'b0, $sformatf("exh%0d", v));
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
